// File: rtl/siso_xfer_pkg.sv
// siso_xfer_pkg
// Shared definitions for the SISO transfer controller:
//   - state_t   : FSM state encoding (IDLE, SHIFT, FLUSH, DONE)
//   - cnt_width : width of the edge counter, which must hold DATA_W+SR_DEPTH
package siso_xfer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int cnt_width(input int data_w, input int sr_depth);
        return $clog2(data_w + sr_depth + 1);
    endfunction

endpackage

// File: rtl/siso_xfer_bitcnt.sv
// siso_xfer_bitcnt
// Loadable edge counter for the transfer sequencer.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   i_clr           : load 0 (acceptance edge), has priority over i_en
//   i_en            : count this edge (SHIFT/FLUSH)
//   o_cnt           : current count = edges since acceptance
//   o_last_shift    : the coming counted edge reaches DATA_W
//   o_last_cap      : the coming counted edge reaches DATA_W+SR_DEPTH
// Both terminal flags look one edge ahead so the FSM can change state on
// exactly the edge where the count reaches its terminal value.
module siso_xfer_bitcnt
    import siso_xfer_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int SR_DEPTH = 4,
    parameter int CNT_W    = cnt_width(DATA_W, SR_DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_last_shift,
    output logic             o_last_cap
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt        = r_cnt;
    assign o_last_shift = i_en && (r_cnt == CNT_W'(DATA_W - 1));
    assign o_last_cap   = i_en && (r_cnt == CNT_W'(DATA_W + SR_DEPTH - 1));

endmodule

// File: rtl/siso_xfer_ctrl.sv
// siso_xfer_ctrl
// Sequencer for a SISO shift-register chain. Accepts a parallel word,
// shifts it MSB-first onto sr_sdi, flushes with zeros, captures the bits
// emerging on sr_sdo and returns the reassembled word.
// Ports:
//   clk, reset_n          : clock (shared with chain), async active-low reset
//   in_valid/in_data      : producer word, accepted when in_ready=1
//   in_ready              : registered, high only in IDLE
//   sr_sdi                : registered serial bit into the chain
//   sr_sdo                : serial bit from the chain's last stage
//   out_valid/out_data    : received word, held until out_ready
//   out_ready             : consumer accept
//   busy                  : state != IDLE
//   err                   : loopback mismatch (sticky)
// Optional feature: define SISO_XFER_LOOPBACK_CHECK_EN to compare the
// received word with the transmitted one; otherwise err is tied low.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid/data are held by the source until that edge.
module siso_xfer_ctrl
    import siso_xfer_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int SR_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              sr_sdi,
    input  logic              sr_sdo,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = cnt_width(DATA_W, SR_DEPTH);

    state_t            r_state;
    logic              r_in_ready;
    logic              r_sr_sdi;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] r_tx_sh;
    logic [DATA_W-1:0] r_rx;

    logic              w_accept;
    logic              w_run;
    logic              w_cap;
    logic [DATA_W-1:0] w_rx_nxt;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_last_shift;
    logic              w_last_cap;

    assign w_accept = (r_state == ST_IDLE) && in_valid && r_in_ready;
    assign w_run    = (r_state == ST_SHIFT) || (r_state == ST_FLUSH);
    // The first SR_DEPTH counted edges only see whatever the chain held
    // before the word reached its end, so sampling starts after them.
    assign w_cap    = w_run && (w_cnt >= CNT_W'(SR_DEPTH));
    assign w_rx_nxt = {r_rx[DATA_W-2:0], sr_sdo};

    siso_xfer_bitcnt #(
        .DATA_W   (DATA_W),
        .SR_DEPTH (SR_DEPTH),
        .CNT_W    (CNT_W)
    ) u_bitcnt (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_clr        (w_accept),
        .i_en         (w_run),
        .o_cnt        (w_cnt),
        .o_last_shift (w_last_shift),
        .o_last_cap   (w_last_cap)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_sr_sdi    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_tx_sh     <= '0;
            r_rx        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    r_sr_sdi   <= 1'b0;
                    if (w_accept) begin
                        // MSB goes out on the acceptance edge; the shifter
                        // keeps the remaining bits left-aligned.
                        r_sr_sdi   <= in_data[DATA_W-1];
                        r_tx_sh    <= in_data << 1;
                        r_rx       <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_sr_sdi <= r_tx_sh[DATA_W-1];
                    r_tx_sh  <= r_tx_sh << 1;
                    if (w_cap) begin
                        r_rx <= w_rx_nxt;
                    end
                    if (w_last_shift) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    r_sr_sdi <= 1'b0;
                    if (w_cap) begin
                        r_rx <= w_rx_nxt;
                    end
                    if (w_last_cap) begin
                        r_out_data  <= w_rx_nxt;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign sr_sdi    = r_sr_sdi;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_state != ST_IDLE);

`ifdef SISO_XFER_LOOPBACK_CHECK_EN
    logic [DATA_W-1:0] r_tx_word;
    logic              r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_word <= '0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_tx_word <= in_data;
            r_err     <= 1'b0;
        end else if (w_last_cap) begin
            r_err <= (w_rx_nxt != r_tx_word);
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_siso_xfer_ctrl.sv
module tb_siso_xfer_ctrl;

  localparam int W = 8;
  localparam int D = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         sr_sdi;
  logic         sr_sdo;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         busy;
  logic         err;
  logic         tb_flip;

  // 4-stage SISO chain; tb_flip inverts its output for fault injection
  logic [D-1:0] chain;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) chain <= '0;
    else          chain <= {chain[D-2:0], sr_sdi};
  end
  assign sr_sdo = chain[D-1] ^ tb_flip;

  siso_xfer_ctrl #(.DATA_W(W), .SR_DEPTH(D)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .sr_sdi    (sr_sdi),
    .sr_sdo    (sr_sdo),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .err       (err)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: word as seen at the far end with stream bit j inverted
  function automatic logic [W-1:0] model_rx(input logic [W-1:0] word, input int fault_j);
    logic [W-1:0] m;
    m = word;
    if (fault_j >= 0) m[W-1-fault_j] = ~m[W-1-fault_j];
    return m;
  endfunction

  function automatic logic model_err(input int fault_j);
`ifdef SISO_XFER_LOOPBACK_CHECK_EN
    return (fault_j >= 0);
`else
    return 1'b0;
`endif
  endfunction

  // Full transfer, entered and left at a falling edge.
  task automatic xfer(input logic [W-1:0] word, input int fault_j, input int bp,
                      input bit hold_next, input logic [W-1:0] next_word);
    logic [W-1:0] exp_w;
    logic [W-1:0] held;
    logic         exp_e;
    logic         exp_bit;
    bit           ok;
    exp_q.push_back(model_rx(word, fault_j));
    exp_e     = model_err(fault_j);
    out_ready = (bp == 0);
    in_data   = word;
    in_valid  = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (hold_next) in_data = next_word;
    else           in_valid = 1'b0;
    for (int k = 0; k < W + D; k++) begin
      exp_bit = (k < W) ? word[W-1-k] : 1'b0;
      check("sr_sdi", 32'(sr_sdi), 32'(exp_bit));
      check("out_valid_early", 32'(out_valid), 32'd0);
      check("in_ready_busy", 32'(in_ready), 32'd0);
      check("busy_run", 32'(busy), 32'd1);
      if (k == 0) check("err_clear", 32'(err), 32'd0);
      tb_flip = (fault_j >= 0) && (k == fault_j + D);
      @(negedge clk);
    end
    tb_flip = 1'b0;
    exp_w = exp_q.pop_front();
    check("out_valid", 32'(out_valid), 32'd1);
    check("out_data", 32'(out_data), 32'(exp_w));
    check("err_done", 32'(err), 32'(exp_e));
    held = out_data;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'(held));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
    check("err_sticky", 32'(err), 32'(exp_e));
  endtask

  // Transfer abandoned by reset at the falling edge after E_abort_k.
  task automatic xfer_abort(input logic [W-1:0] word, input int abort_k);
    in_data  = word;
    in_valid = 1'b1;
    while (!in_ready) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < abort_k; k++) @(negedge clk);
    check("abort_sdi_pre", 32'(sr_sdi), 32'(word[W-1-abort_k]));
    reset_n = 1'b0;
    #1;
    check("abort_sdi", 32'(sr_sdi), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tb_flip   = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_sdi", 32'(sr_sdi), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("first_in_ready", 32'(in_ready), 32'd1);

    // directed cases
    xfer(8'hA5, -1, 0, 1'b0, 8'h00);
    xfer(8'h3C, -1, 5, 1'b0, 8'h00);
    xfer(8'h01, -1, 2, 1'b1, 8'hFF);
    xfer(8'hFF, -1, 0, 1'b0, 8'h00);
    xfer_abort(8'hF0, 6);
    xfer(8'h81, -1, 0, 1'b0, 8'h00);
    xfer(8'h00, 3, 1, 1'b0, 8'h00);
    xfer(8'h5A, -1, 0, 1'b0, 8'h00);

    // randomized traffic
    for (int n = 0; n < 25; n++) begin
      logic [W-1:0] w;
      int f;
      w = W'($urandom_range(0, 255));
      f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W-1)) : -1;
      xfer(w, f, int'($urandom_range(0, 3)), 1'b0, 8'h00);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
